off_on_seq_coder: RTL and testbench

//   Parametrised off/on gate sequencer for the NMR transmit/receive switch path.
//   On a start strobe it plays N repetitions of {OFF for off_w clk, ON for on_w clk}.

---
 rtl/off_on_seq_coder_if.sv | 26 ++
 rtl/off_on_seq_coder.sv | 139 +++++++++++++
 tb/tb_off_on_seq_coder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/off_on_seq_coder_if.sv
// Control and status bundle between the pulse-sequence controller and the off/on gate sequencer.
interface off_on_seq_coder_if #(
    parameter int CNT_W = 8,
    parameter int REP_W = 8,
    parameter int NCH   = 2
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] off_w;
    logic [CNT_W-1:0] on_w;
    logic [REP_W-1:0] rep_num;
    logic [NCH-1:0]   ch_mask;
    logic [NCH-1:0]   ch_out;
    logic [1:0]       i;
    logic             done;

    modport master (
        output start, abort, off_w, on_w, rep_num, ch_mask,
        input  ch_out, i, done
    );

    modport slave (
        input  start, abort, off_w, on_w, rep_num, ch_mask,
        output ch_out, i, done
    );
endinterface

// File: rtl/off_on_seq_coder.sv
// Off/on gate sequencer: N repetitions of {OFF off_w clk, ON on_w clk}, with the mask on the gates during ON.
//
// state | meaning
// IDLE  | waiting for start; outputs 0
// OFF   | gates low, phase counter runs up to off_w
// ON    | gates = latched mask, phase counter runs up to on_w
// DONE  | single-cycle done strobe, then back to IDLE
module off_on_seq_coder #(
    parameter int CNT_W = 8,
    parameter int REP_W = 8,
    parameter int NCH   = 2
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    off_on_seq_coder_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OFF  = 2'd1,
        S_ON   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] off_q, off_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic [REP_W-1:0] repn_q, repn_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [NCH-1:0]   ch_out_q, ch_out_d;
    logic             busy_q, busy_d;
    logic             edge_q, edge_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rep_q    <= '0;
            off_q    <= '0;
            on_q     <= '0;
            repn_q   <= '0;
            mask_q   <= '0;
            ch_out_q <= '0;
            busy_q   <= 1'b0;
            edge_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rep_q    <= rep_d;
            off_q    <= off_d;
            on_q     <= on_d;
            repn_q   <= repn_d;
            mask_q   <= mask_d;
            ch_out_q <= ch_out_d;
            busy_q   <= busy_d;
            edge_q   <= edge_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        off_d   = off_q;
        on_d    = on_q;
        repn_d  = repn_q;
        mask_d  = mask_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = S_OFF;
                    cnt_d   = CNT_W'(1);
                    rep_d   = '0;
                    // Zero widths/counts are clamped to 1 so the equality compares always terminate
                    off_d   = (bus.off_w == '0) ? CNT_W'(1) : bus.off_w;
                    on_d    = (bus.on_w == '0) ? CNT_W'(1) : bus.on_w;
                    repn_d  = (bus.rep_num == '0) ? REP_W'(1) : bus.rep_num;
                    mask_d  = bus.ch_mask;
                end
            end
            S_OFF: begin
                if (cnt_q == off_q) begin
                    state_d = S_ON;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ON: begin
                if (cnt_q == on_q) begin
                    // repn_q >= 1, so the decrement cannot wrap and rep_q never exceeds repn_q-1
                    if (rep_q == repn_q - REP_W'(1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_OFF;
                        cnt_d   = CNT_W'(1);
                        rep_d   = rep_q + REP_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                rep_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rep_d   = '0;
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state
    always_comb begin
        busy_d   = (state_d == S_OFF) || (state_d == S_ON);
        ch_out_d = (state_d == S_ON) ? mask_d : '0;
        edge_d   = (state_q == S_OFF) && (state_d == S_ON);
        done_d   = (state_d == S_DONE);
    end

    assign bus.ch_out = ch_out_q;
    assign bus.i      = {edge_q, busy_q};
    assign bus.done   = done_q;

endmodule

// File: tb/tb_off_on_seq_coder.sv
// Scoreboard bench for off_on_seq_coder: per-cycle expected {ch_out, i, done} queued at start, popped each cycle.
module tb_off_on_seq_coder;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;

    always #5 clk_sys = ~clk_sys;

    off_on_seq_coder_if #(.CNT_W(8), .REP_W(8), .NCH(2)) bus8 ();
    off_on_seq_coder_if #(.CNT_W(4), .REP_W(8), .NCH(2)) bus4 ();

    off_on_seq_coder #(.CNT_W(8), .REP_W(8), .NCH(2)) dut8 (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus8.slave)
    );

    off_on_seq_coder #(.CNT_W(4), .REP_W(8), .NCH(2)) dut4 (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus4.slave)
    );

    logic [4:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Expected trace for cycles t0 .. t0+len-1; abort_at < 0 means no abort
    function automatic void push_seq(input int off, input int on, input int n,
                                     input logic [1:0] mask, input int abort_at, input int len);
        int p, k, r;
        logic [4:0] e;
        if (off == 0) off = 1;
        if (on == 0) on = 1;
        if (n == 0) n = 1;
        p = off + on;
        for (int c = 0; c < len; c++) begin
            e = 5'b0;
            if (abort_at >= 0 && c >= abort_at) begin
                e = 5'b0;
            end else if (c < n * p) begin
                k = c / p;
                r = c - k * p;
                e[4:3] = (r >= off) ? mask : 2'b00;
                e[2]   = (r == off);
                e[1]   = 1'b1;
            end else if (c == n * p) begin
                e[0] = 1'b1;
            end
            exp_q.push_back(e);
        end
    endfunction

    function automatic void push_idle(input int len);
        for (int c = 0; c < len; c++) exp_q.push_back(5'b0);
    endfunction

    task automatic set8(input int off, input int on, input int n, input logic [1:0] mask);
        bus8.off_w   = 8'(off);
        bus8.on_w    = 8'(on);
        bus8.rep_num = 8'(n);
        bus8.ch_mask = mask;
    endtask

    task automatic test_reset();
        logic [4:0] e, got;
        push_idle(2);
        push_idle(2);
        for (int c = 0; c < 2; c++) begin
            e = exp_q.pop_front();
            got = {bus8.ch_out, bus8.i, bus8.done};
            n_checks++;
            if (got !== e) $display("FAIL reset8 c=%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            e = exp_q.pop_front();
            got = {bus4.ch_out, bus4.i, bus4.done};
            n_checks++;
            if (got !== e) $display("FAIL reset4 c=%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            @(negedge clk_sys);
        end
    endtask

    task automatic test_basic();
        logic [4:0] e, got;
        @(negedge clk_sys);
        set8(3, 2, 2, 2'b01);
        bus8.start = 1'b1;
        push_seq(3, 2, 2, 2'b01, -1, 13);
        for (int c = 0; c < 13; c++) begin
            @(negedge clk_sys);
            e = exp_q.pop_front();
            got = {bus8.ch_out, bus8.i, bus8.done};
            n_checks++;
            if (got !== e) $display("FAIL basic c=%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 0) bus8.start = 1'b0;
        end
    endtask

    task automatic test_zero_clamp();
        logic [4:0] e, got;
        @(negedge clk_sys);
        set8(0, 0, 0, 2'b11);
        bus8.start = 1'b1;
        push_seq(0, 0, 0, 2'b11, -1, 5);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_sys);
            e = exp_q.pop_front();
            got = {bus8.ch_out, bus8.i, bus8.done};
            n_checks++;
            if (got !== e) $display("FAIL zero_clamp c=%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 0) bus8.start = 1'b0;
        end
    endtask

    task automatic test_latch_ignore();
        logic [4:0] e, got;
        @(negedge clk_sys);
        set8(3, 2, 2, 2'b01);
        bus8.start = 1'b1;
        push_seq(3, 2, 2, 2'b01, -1, 13);
        for (int c = 0; c < 13; c++) begin
            @(negedge clk_sys);
            e = exp_q.pop_front();
            got = {bus8.ch_out, bus8.i, bus8.done};
            n_checks++;
            if (got !== e) $display("FAIL latch_ignore c=%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 0) begin
                bus8.start   = 1'b0;
                bus8.off_w   = 8'd7;
                bus8.ch_mask = 2'b10;
            end
            if (c == 3) bus8.start = 1'b1;
            if (c == 4) bus8.start = 1'b0;
        end
        set8(3, 2, 2, 2'b01);
    endtask

    task automatic test_abort();
        logic [4:0] e, got;
        @(negedge clk_sys);
        set8(3, 2, 2, 2'b01);
        bus8.start = 1'b1;
        push_seq(3, 2, 2, 2'b01, 6, 13);
        for (int c = 0; c < 13; c++) begin
            @(negedge clk_sys);
            e = exp_q.pop_front();
            got = {bus8.ch_out, bus8.i, bus8.done};
            n_checks++;
            if (got !== e) $display("FAIL abort c=%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 0) bus8.start = 1'b0;
            if (c == 5) bus8.abort = 1'b1;
            if (c == 6) bus8.abort = 1'b0;
        end
        bus8.start = 1'b1;
        bus8.abort = 1'b1;
        push_idle(5);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_sys);
            e = exp_q.pop_front();
            got = {bus8.ch_out, bus8.i, bus8.done};
            n_checks++;
            if (got !== e) $display("FAIL start_abort c=%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 0) begin
                bus8.start = 1'b0;
                bus8.abort = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e, got;
        @(negedge clk_sys);
        set8(1, 1, 1, 2'b10);
        bus8.start = 1'b1;
        // start held through the DONE cycle is ignored, accepted once IDLE again
        push_seq(1, 1, 1, 2'b10, -1, 4);
        push_seq(1, 1, 1, 2'b10, -1, 4);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_sys);
            e = exp_q.pop_front();
            got = {bus8.ch_out, bus8.i, bus8.done};
            n_checks++;
            if (got !== e) $display("FAIL back_to_back c=%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 0) bus8.start = 1'b0;
            if (c == 2) bus8.start = 1'b1;
            if (c == 4) bus8.start = 1'b0;
        end
    endtask

    task automatic test_reset_mid_on();
        logic [4:0] e, got;
        @(negedge clk_sys);
        set8(4, 4, 2, 2'b01);
        bus8.start = 1'b1;
        // reset edges at t0+6..t0+8 look like an abort on the outputs
        push_seq(4, 4, 2, 2'b01, 6, 16);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_sys);
            e = exp_q.pop_front();
            got = {bus8.ch_out, bus8.i, bus8.done};
            n_checks++;
            if (got !== e) $display("FAIL reset_mid_on c=%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 0) bus8.start = 1'b0;
            if (c == 5) rst_n = 1'b0;
            if (c == 8) rst_n = 1'b1;
        end
    endtask

    task automatic test_max_width();
        logic [4:0] e, got;
        @(negedge clk_sys);
        bus4.off_w   = 4'd15;
        bus4.on_w    = 4'd15;
        bus4.rep_num = 8'd1;
        bus4.ch_mask = 2'b11;
        bus4.start   = 1'b1;
        push_seq(15, 15, 1, 2'b11, -1, 33);
        for (int c = 0; c < 33; c++) begin
            @(negedge clk_sys);
            e = exp_q.pop_front();
            got = {bus4.ch_out, bus4.i, bus4.done};
            n_checks++;
            if (got !== e) $display("FAIL max_width c=%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 0) bus4.start = 1'b0;
        end
    endtask

    initial begin
        bus8.start = 1'b0; bus8.abort = 1'b0;
        bus8.off_w = '0; bus8.on_w = '0; bus8.rep_num = '0; bus8.ch_mask = '0;
        bus4.start = 1'b0; bus4.abort = 1'b0;
        bus4.off_w = '0; bus4.on_w = '0; bus4.rep_num = '0; bus4.ch_mask = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_zero_clamp();
        test_latch_ignore();
        test_abort();
        test_back_to_back();
        test_reset_mid_on();
        test_max_width();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
